// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, op predicates
// and the iteration FSM state type.
package hilo_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FIXUP = 2'd3
    } hiloStateT;

    function automatic logic is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_acc(input logic [3:0] op);
        return (op >= OP_MADD) && (op <= OP_MSUBU);
    endfunction

    function automatic logic is_sub(input logic [3:0] op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-divide iteration: shift in the next dividend bit, subtract the
// divisor and keep the difference only when it does not go negative.
module hilo_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] remIn,
    input  logic [XLEN-1:0] divisor,
    input  logic            dividendBit,
    output logic [XLEN-1:0] remOut,
    output logic            quotBit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {remIn, dividendBit};
        diff    = shifted - {1'b0, divisor};
        quotBit = (shifted >= {1'b0, divisor});
        remOut  = quotBit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide engine: one bit per cycle on magnitudes,
// sign correction and MADD/MSUB accumulation in a final FIXUP cycle.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [3:0]      Op,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic            StallReq,
    output logic [XLEN-1:0] HIRegOutput,
    output logic [XLEN-1:0] LORegOutput
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    hiloStateT         state;
    logic [CNT_W-1:0]  counter;
    logic [XLEN-1:0]   hiReg, loReg, mcand;
    logic [2*XLEN-1:0] prod;
    logic [3:0]        opReg;
    logic              busyReg, doneReg, negResult, negRem, divZero;

    logic [XLEN-1:0]   absA, absB, remNext, quot, rem;
    logic [XLEN:0]     mulSum;
    logic [2*XLEN-1:0] signedProd, accSum;
    logic              qBit;

    // prod holds {partial product, multiplier} in MUL and {remainder, dividend/quotient} in DIV
    hilo_div_step #(.XLEN(XLEN)) uDivStep (
        .remIn      (prod[2*XLEN-1:XLEN]),
        .divisor    (mcand),
        .dividendBit(prod[XLEN-1]),
        .remOut     (remNext),
        .quotBit    (qBit)
    );

    always_comb begin
        absA       = (is_signed(Op) && SrcA[XLEN-1]) ? -SrcA : SrcA;
        absB       = (is_signed(Op) && SrcB[XLEN-1]) ? -SrcB : SrcB;
        mulSum     = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
        signedProd = negResult ? -prod : prod;
        accSum     = is_sub(opReg) ? ({hiReg, loReg} - signedProd) : ({hiReg, loReg} + signedProd);
        quot       = negResult ? -prod[XLEN-1:0] : prod[XLEN-1:0];
        // On divide by zero the remainder path reproduces the raw dividend
        rem        = negRem ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            counter   <= '0;
            hiReg     <= '0;
            loReg     <= '0;
            mcand     <= '0;
            prod      <= '0;
            opReg     <= '0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            negResult <= 1'b0;
            negRem    <= 1'b0;
            divZero   <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && !Flush) begin
                        if (Op == OP_MTHI) begin
                            hiReg <= SrcA;
                        end else if (Op == OP_MTLO) begin
                            loReg <= SrcA;
                        end else if (Op <= OP_MSUBU) begin
                            opReg     <= Op;
                            counter   <= CNT_W'(XLEN);
                            busyReg   <= 1'b1;
                            negRem    <= is_signed(Op) && SrcA[XLEN-1];
                            negResult <= is_signed(Op) && (SrcA[XLEN-1] ^ SrcB[XLEN-1]);
                            divZero   <= is_div(Op) && (SrcB == '0);
                            if (is_div(Op)) begin
                                state <= DIV;
                                mcand <= absB;
                                prod  <= {{XLEN{1'b0}}, absA};
                            end else begin
                                state <= MUL;
                                mcand <= absA;
                                prod  <= {{XLEN{1'b0}}, absB};
                            end
                        end
                    end
                end
                MUL, DIV: begin
                    if (Flush) begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
                        counter <= '0;
                    end else begin
                        counter <= counter - CNT_W'(1);
                        if (state == MUL) prod <= {mulSum, prod[XLEN-1:1]};
                        else              prod <= {remNext, prod[XLEN-2:0], qBit};
                        if (counter == CNT_W'(1)) state <= FIXUP;
                    end
                end
                FIXUP: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                    if (!Flush) begin
                        doneReg <= 1'b1;
                        if (is_div(opReg)) begin
                            hiReg <= rem;
                            loReg <= divZero ? '1 : quot;
                        end else if (is_acc(opReg)) begin
                            {hiReg, loReg} <= accSum;
                        end else begin
                            {hiReg, loReg} <= signedProd;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy        = busyReg;
    assign StallReq    = busyReg;
    assign Done        = doneReg;
    assign HIRegOutput = hiReg;
    assign LORegOutput = loReg;

    // Requests arriving while busy are dropped; the pipeline must hold them off
    assert property (@(posedge Clk) disable iff (!Reset) Busy |-> !Start);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed corner cases plus random ops compared
// against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_unit;

    logic        Clk, Reset, Start, Flush;
    logic [3:0]  Op;
    logic [31:0] SrcA, SrcB;
    logic        Busy, Done, StallReq;
    logic [31:0] HIRegOutput, LORegOutput;

    int checkCount = 0;
    int errorCount = 0;
    logic [63:0] modelHiLo = '0;
    logic [63:0] exp_q[$];

    hilo_muldiv_unit #(.XLEN(32)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Op         (Op),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Flush      (Flush),
        .Busy       (Busy),
        .Done       (Done),
        .StallReq   (StallReq),
        .HIRegOutput(HIRegOutput),
        .LORegOutput(LORegOutput)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkValue(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Architectural result of one op applied to the current {HI,LO}
    function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hilo);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, sp, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        sp = sa * sb;
        up = ua * ub;
        case (op)
            4'd0: return sp;
            4'd1: return up;
            4'd2, 4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (op == 4'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
            4'd4: return hilo + sp;
            4'd5: return hilo + up;
            4'd6: return hilo - sp;
            4'd7: return hilo - up;
            4'd8: return {a, hilo[31:0]};
            4'd9: return {hilo[63:32], a};
            default: return hilo;
        endcase
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Iterative op: checks busy length, done latency, result and the done pulse width
    task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int lat, busyCnt, stallBad;
        logic [63:0] expVal;
        exp_q.push_back(refResult(op, a, b, modelHiLo));
        @(posedge Clk); #1;
        Start = 1'b1; Op = op; SrcA = a; SrcB = b;
        @(posedge Clk); #1;
        Start = 1'b0;
        lat = 0; busyCnt = 0; stallBad = 0;
        while (!Done && lat < 100) begin
            if (Busy) busyCnt++;
            if (StallReq !== Busy) stallBad++;
            @(posedge Clk); #1;
            lat++;
        end
        expVal = exp_q.pop_front();
        modelHiLo = expVal;
        checkValue({tag, " latency"}, 64'(lat), 64'd33);
        checkValue({tag, " busy_cycles"}, 64'(busyCnt), 64'd33);
        checkValue({tag, " stall_eq_busy"}, 64'(stallBad), 64'd0);
        checkValue({tag, " hilo"}, {HIRegOutput, LORegOutput}, expVal);
        checkValue({tag, " busy_at_done"}, {62'd0, Busy, StallReq}, 64'd0);
        @(posedge Clk); #1;
        checkValue({tag, " done_pulse"}, {63'd0, Done}, 64'd0);
    endtask

    // Single-cycle or ignored op: no Busy, no Done
    task automatic simpleOp(input logic [3:0] op, input logic [31:0] a, input string tag);
        modelHiLo = refResult(op, a, 32'd0, modelHiLo);
        @(posedge Clk); #1;
        Start = 1'b1; Op = op; SrcA = a; SrcB = $urandom;
        @(posedge Clk); #1;
        Start = 1'b0;
        checkValue({tag, " busy_done"}, {62'd0, Busy, Done}, 64'd0);
        checkValue({tag, " hilo"}, {HIRegOutput, LORegOutput}, modelHiLo);
    endtask

    initial begin
        int sawDone;
        logic [3:0] rop;
        Reset = 1'b0; Start = 1'b0; Flush = 1'b0; Op = '0; SrcA = '0; SrcB = '0;
        repeat (3) @(posedge Clk);
        #1;
        checkValue("reset hilo", {HIRegOutput, LORegOutput}, 64'd0);
        checkValue("reset busy_done", {62'd0, Busy, Done}, 64'd0);
        Reset = 1'b1;

        runOp(4'd0, 32'hFFFFFFFD, 32'd7, "mult_neg3x7");
        checkValue("mult_neg3x7 literal", {HIRegOutput, LORegOutput}, 64'hFFFFFFFF_FFFFFFEB);
        runOp(4'd3, 32'd100, 32'd7, "divu_100_7");
        checkValue("divu_100_7 literal", {HIRegOutput, LORegOutput}, 64'h00000002_0000000E);
        runOp(4'd2, 32'hFFFFFFF9, 32'd2, "div_neg7_2");
        checkValue("div_neg7_2 literal", {HIRegOutput, LORegOutput}, 64'hFFFFFFFF_FFFFFFFD);

        simpleOp(4'd8, 32'd0, "mthi_0");
        simpleOp(4'd9, 32'hFFFFFFFF, "mtlo_ones");
        runOp(4'd5, 32'd1, 32'd1, "maddu_carry");
        checkValue("maddu_carry literal", {HIRegOutput, LORegOutput}, 64'h00000001_00000000);
        runOp(4'd7, 32'd1, 32'd1, "msubu_borrow");
        checkValue("msubu_borrow literal", {HIRegOutput, LORegOutput}, 64'h00000000_FFFFFFFF);

        runOp(4'd3, 32'd5, 32'd0, "divu_by_zero");
        checkValue("divu_by_zero literal", {HIRegOutput, LORegOutput}, 64'h00000005_FFFFFFFF);
        runOp(4'd2, 32'h80000000, 32'hFFFFFFFF, "div_minneg");
        checkValue("div_minneg literal", {HIRegOutput, LORegOutput}, 64'h00000000_80000000);
        runOp(4'd2, 32'hFFFFFFF9, 32'd0, "div_neg_by_zero");

        // Flush mid-multiply
        simpleOp(4'd8, 32'h12345678, "mthi_pre_flush");
        simpleOp(4'd9, 32'h12345678, "mtlo_pre_flush");
        @(posedge Clk); #1;
        Start = 1'b1; Op = 4'd0; SrcA = $urandom; SrcB = $urandom;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        Flush = 1'b1;
        @(posedge Clk); #1;
        Flush = 1'b0;
        checkValue("flush busy", {63'd0, Busy}, 64'd0);
        sawDone = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (Done) sawDone++;
        end
        checkValue("flush no_done", 64'(sawDone), 64'd0);
        checkValue("flush hilo", {HIRegOutput, LORegOutput}, modelHiLo);

        // Flush beats Start in IDLE, even for MTLO
        @(posedge Clk); #1;
        Start = 1'b1; Op = 4'd9; SrcA = 32'hDEADBEEF; Flush = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; Flush = 1'b0;
        checkValue("flush_mtlo hilo", {HIRegOutput, LORegOutput}, modelHiLo);

        // Flush on the FIXUP edge suppresses the write and Done
        @(posedge Clk); #1;
        Start = 1'b1; Op = 4'd3; SrcA = 32'd100; SrcB = 32'd7;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (32) @(posedge Clk);
        #1;
        checkValue("pre_fixup busy", {63'd0, Busy}, 64'd1);
        Flush = 1'b1;
        @(posedge Clk); #1;
        Flush = 1'b0;
        checkValue("fixup_flush busy_done", {62'd0, Busy, Done}, 64'd0);
        checkValue("fixup_flush hilo", {HIRegOutput, LORegOutput}, modelHiLo);

        // Async reset mid-divide
        @(posedge Clk); #1;
        Start = 1'b1; Op = 4'd3; SrcA = 32'd1000; SrcB = 32'd3;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        modelHiLo = '0;
        checkValue("midreset hilo", {HIRegOutput, LORegOutput}, 64'd0);
        checkValue("midreset busy", {63'd0, Busy}, 64'd0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        runOp(4'd1, 32'd3, 32'd4, "multu_after_reset");
        checkValue("multu_after_reset literal", {HIRegOutput, LORegOutput}, 64'h00000000_0000000C);

        // Randomized mix of every op code
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (rop <= 4'd7) runOp(rop, randOperand(), randOperand(), $sformatf("rand%0d_op%0d", i, rop));
            else             simpleOp(rop, randOperand(), $sformatf("rand%0d_op%0d", i, rop));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
